// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO family: occupancy-counter and pointer widths.
package fifo_pkg;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular-buffer pointer: advances on inc and wraps from DEPTH-1 back to 0.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (clear) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/level_fifo.sv
// Show-ahead FIFO with arbitrary depth, level flags and sticky overflow/underflow.
module level_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 10,
  parameter  int AFULL_TH  = DEPTH - 2,
  parameter  int AEMPTY_TH = 2,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              write,
  input  logic [DATA_W-1:0] in,
  input  logic              read,
  input  logic              err_clr,
  output logic [DATA_W-1:0] out,
  output logic              val,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              afull,
  output logic              aempty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ptr_w(DEPTH);

  generate
    if (DEPTH < 2 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_params
      $error("level_fifo: need DEPTH >= 2 and AEMPTY_TH < AFULL_TH <= DEPTH");
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push, pop;

  // All flags come from the registered count, so no input reaches an output combinationally.
  assign val    = (count_q != '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign afull  = (int'(count_q) >= AFULL_TH);
  assign aempty = (int'(count_q) <= AEMPTY_TH);

  // A pop frees the slot the push needs, so a full FIFO still accepts a push alongside a pop.
  assign pop  = read && val && !clear;
  assign push = write && (!full || (read && val)) && !clear;

  fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (pop),
    .ptr_o (rd_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (push),
    .ptr_o (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // Setting wins over err_clr in the same cycle so no error event is lost.
    ovf_d = ovf_q & ~err_clr;
    udf_d = udf_q & ~err_clr;
    if (!clear) begin
      if (write && full && !read) ovf_d = 1'b1;
      if (read && !val)           udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= clear ? '0 : count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: storage is deliberately not reset; val gates its contents, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr] <= in;
    end
  end

  assign out       = mem_q[rd_ptr];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_level_fifo.sv
// Directed and model-checked bench for level_fifo (DATA_W=8, DEPTH=10, AFULL_TH=8, AEMPTY_TH=2).
module tb_level_fifo;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr, rd, eclr;
  logic [7:0] din, dout;
  logic       val, full, afull, aempty, ovf, udf;
  logic [3:0] cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q[$];

  level_fifo #(.DATA_W(8), .DEPTH(10), .AFULL_TH(8), .AEMPTY_TH(2)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .clear     (clr),
    .write     (wr),
    .in        (din),
    .read      (rd),
    .err_clr   (eclr),
    .out       (dout),
    .val       (val),
    .full      (full),
    .count     (cnt),
    .afull     (afull),
    .aempty    (aempty),
    .overflow  (ovf),
    .underflow (udf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, update the reference queue, then settle 1 ns past the edge.
  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    logic pop_m, push_m;
    wr = w; din = d; rd = r;
    pop_m  = r && (q.size() > 0);
    push_m = w && ((q.size() < 10) || pop_m);
    if (rst_n && !clr) begin
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; eclr = 1'b0; din = '0;
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    vectors++;
    if ({cnt, val, full, afull, aempty, ovf, udf} !== {4'd0, 6'b000100}) begin
      miscompares++;
      $display("FAIL reset {cnt,val,full,afull,aempty,ovf,udf} got %b want %b",
               {cnt, val, full, afull, aempty, ovf, udf}, {4'd0, 6'b000100});
    end
    rst_n = 1'b1;
    drive(0, 8'h00, 0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) begin
      logic [15:0] exp;
      drive(1, 8'(i), 0);
      exp = {4'(i + 1), (i == 9), (i >= 7), (i <= 1), 1'b1, 8'h00};
      vectors++;
      if ({cnt, full, afull, aempty, val, dout} !== exp) begin
        miscompares++;
        $display("FAIL fill[%0d] {cnt,full,afull,aempty,val,out} got %h want %h",
                 i, {cnt, full, afull, aempty, val, dout}, exp);
      end
    end
  endtask

  task automatic test_pass_through();
    drive(1, 8'hAA, 1);
    vectors++;
    if ({dout, cnt, full, ovf} !== {8'h01, 4'd10, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL pass_through {out,cnt,full,ovf} got %h want %h",
               {dout, cnt, full, ovf}, {8'h01, 4'd10, 1'b1, 1'b0});
    end
    for (int k = 0; k < 10; k++) begin
      logic [7:0] exp;
      exp = (k < 9) ? 8'(k + 1) : 8'hAA;
      vectors++;
      if (val !== 1'b1 || dout !== exp) begin
        miscompares++;
        $display("FAIL drain[%0d] val=%b out=%h want val=1 out=%h", k, val, dout, exp);
      end
      drive(0, 8'h00, 1);
    end
    vectors++;
    if ({cnt, val, aempty} !== {4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL drained {cnt,val,aempty} got %h want %h", {cnt, val, aempty}, {4'd0, 2'b01});
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 10; i++) drive(1, 8'(8'h10 + i), 0);
    drive(1, 8'h55, 0);
    vectors++;
    if ({ovf, udf, cnt, dout} !== {1'b1, 1'b0, 4'd10, 8'h10}) begin
      miscompares++;
      $display("FAIL overflow {ovf,udf,cnt,out} got %h want %h", {ovf, udf, cnt, dout},
               {1'b1, 1'b0, 4'd10, 8'h10});
    end
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (dout !== 8'(8'h10 + k)) begin
        miscompares++;
        $display("FAIL ovf_drain[%0d] out got %h want %h", k, dout, 8'(8'h10 + k));
      end
      drive(0, 8'h00, 1);
    end
    drive(0, 8'h00, 1);
    vectors++;
    if ({udf, ovf, cnt, val} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL underflow {udf,ovf,cnt,val} got %b want %b", {udf, ovf, cnt, val}, 7'b1100000);
    end
    eclr = 1'b1;
    drive(0, 8'h00, 1);
    vectors++;
    if ({udf, ovf} !== 2'b10) begin
      miscompares++;
      $display("FAIL set_beats_clr {udf,ovf} got %b want 10", {udf, ovf});
    end
    drive(0, 8'h00, 0);
    eclr = 1'b0;
    vectors++;
    if ({udf, ovf} !== 2'b00) begin
      miscompares++;
      $display("FAIL err_clr {udf,ovf} got %b want 00", {udf, ovf});
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 25; i++) begin
      logic w, r;
      w = (q.size() < 5) && ((i % 3) != 2);
      r = (q.size() > 1) && ((i % 2) == 1);
      drive(w, 8'(8'h30 + i), r);
      vectors++;
      if (val !== (q.size() != 0) || cnt !== 4'(q.size()) || (q.size() != 0 && dout !== q[0])) begin
        miscompares++;
        $display("FAIL wrap[%0d] val=%b cnt=%0d out=%h want cnt=%0d out=%h",
                 i, val, cnt, dout, q.size(), (q.size() != 0) ? q[0] : 8'h00);
      end
    end
  endtask

  task automatic test_clear();
    while (q.size() != 0) drive(0, 8'h00, 1);
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h60 + i), 0);
    vectors++;
    if (cnt !== 4'd6) begin
      miscompares++;
      $display("FAIL pre_clear cnt got %0d want 6", cnt);
    end
    clr = 1'b1;
    drive(1, 8'hEE, 1);
    clr = 1'b0;
    vectors++;
    if ({cnt, val, aempty, full, ovf, udf} !== {4'd0, 5'b01000}) begin
      miscompares++;
      $display("FAIL clear {cnt,val,aempty,full,ovf,udf} got %b want %b",
               {cnt, val, aempty, full, ovf, udf}, {4'd0, 5'b01000});
    end
    drive(1, 8'h77, 0);
    vectors++;
    if ({val, cnt, dout} !== {1'b1, 4'd1, 8'h77}) begin
      miscompares++;
      $display("FAIL after_clear {val,cnt,out} got %h want %h", {val, cnt, dout}, {1'b1, 4'd1, 8'h77});
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 1);
    for (int i = 0; i < 10; i++) drive(1, 8'(8'h80 + i), 0);
    drive(1, 8'h8F, 0);
    vectors++;
    if ({ovf, udf, cnt} !== {2'b11, 4'd10}) begin
      miscompares++;
      $display("FAIL pre_reset {ovf,udf,cnt} got %b want %b", {ovf, udf, cnt}, {2'b11, 4'd10});
    end
    rst_n = 1'b0; clr = 1'b1;
    drive(1, 8'h99, 1);
    rst_n = 1'b1; clr = 1'b0;
    q.delete();
    vectors++;
    if ({cnt, val, full, afull, aempty, ovf, udf} !== {4'd0, 6'b000100}) begin
      miscompares++;
      $display("FAIL reset_mid {cnt,val,full,afull,aempty,ovf,udf} got %b want %b",
               {cnt, val, full, afull, aempty, ovf, udf}, {4'd0, 6'b000100});
    end
    drive(1, 8'h42, 0);
    vectors++;
    if ({val, cnt, dout} !== {1'b1, 4'd1, 8'h42}) begin
      miscompares++;
      $display("FAIL after_reset {val,cnt,out} got %h want %h", {val, cnt, dout}, {1'b1, 4'd1, 8'h42});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic w, r;
      // Alternate write-heavy and read-heavy phases so both full and empty are reached.
      if (((i / 200) % 2) == 0) begin
        w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      drive(w, 8'($urandom), r);
      vectors++;
      if (val !== (q.size() != 0) || full !== (q.size() == 10) || cnt !== 4'(q.size()) ||
          (q.size() != 0 && dout !== q[0])) begin
        miscompares++;
        $display("FAIL random[%0d] val=%b full=%b cnt=%0d out=%h want cnt=%0d out=%h",
                 i, val, full, cnt, dout, q.size(), (q.size() != 0) ? q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pass_through();
    test_errors();
    test_wrap();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
